// File: rtl/mem_mod_pkg.sv
// mem_mod_pkg: shared command encoding for the mem_mod bus slave.
//   CMD_W / SEL_BIT / OP_W describe the 5-bit command word.
//   OP_NOP..OP_GETADDR are the opcode values.
//   cmd_t is the packed view of the command word: {sel, op}.
package mem_mod_pkg;

    localparam int unsigned CMD_W   = 5;
    localparam int unsigned SEL_BIT = 4;
    localparam int unsigned OP_W    = 4;

    localparam logic [OP_W-1:0] OP_NOP     = 4'd0;
    localparam logic [OP_W-1:0] OP_SETADDR = 4'd1;
    localparam logic [OP_W-1:0] OP_WRITE   = 4'd2;
    localparam logic [OP_W-1:0] OP_READ    = 4'd3;
    localparam logic [OP_W-1:0] OP_GETADDR = 4'd4;

    typedef struct packed {
        logic            sel;
        logic [OP_W-1:0] op;
    } cmd_t;

endpackage

// File: rtl/mem_mod_ram.sv
// mem_mod_ram: single-port synchronous RAM with write-first behaviour and no reset.
//   clk   : clock
//   we    : write enable (takes priority over re)
//   re    : read enable; rdata is updated only on a read or a write
//   addr  : word address
//   wdata : write data
//   rdata : registered read data
module mem_mod_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Array storage; a write also forwards the new byte onto rdata.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_mod.sv
// mem_mod: byte-wide command-driven memory slave on a shared tristate bus.
//   clk  : system clock, all state changes on the rising edge
//   rst  : synchronous active-high reset (addr, read byte and oe cleared; RAM kept)
//   cmd  : {select, opcode}; opcodes run only when select is 1
//   data : shared bus; driven by mem_mod for one cycle after READ/GETADDR
// Build option: define AUTO_INC_EN to post-increment the address after every
// WRITE and READ (wrapping); otherwise the address moves only on SETADDR/reset.
module mem_mod
    import mem_mod_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CMD_W-1:0]  cmd,
    inout  wire  [DATA_W-1:0] data
);

`ifdef AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    cmd_t              cmd_s;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] addr_snap;
    logic [ADDR_W-1:0] addr_snap_nxt;
    logic              src_addr;
    logic              src_addr_nxt;
    logic              oe;
    logic              oe_nxt;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rd_byte;

    assign cmd_s = cmd_t'(cmd);

    // Command decode; RAM strobes are suppressed while reset is asserted.
    always_comb begin
        addr_nxt      = addr;
        addr_snap_nxt = addr_snap;
        src_addr_nxt  = src_addr;
        oe_nxt        = 1'b0;
        ram_we        = 1'b0;
        ram_re        = 1'b0;
        if (cmd_s.sel && !rst) begin
            case (cmd_s.op)
                OP_SETADDR: addr_nxt = data[ADDR_W-1:0];
                OP_WRITE: begin
                    ram_we = 1'b1;
                    if (AUTO_INC) addr_nxt = addr + ADDR_W'(1);
                end
                OP_READ: begin
                    ram_re       = 1'b1;
                    oe_nxt       = 1'b1;
                    src_addr_nxt = 1'b0;
                    if (AUTO_INC) addr_nxt = addr + ADDR_W'(1);
                end
                OP_GETADDR: begin
                    oe_nxt        = 1'b1;
                    src_addr_nxt  = 1'b1;
                    addr_snap_nxt = addr;
                end
                default: ;
            endcase
        end
    end

    // Control registers; reset leaves the read byte selecting a zeroed snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            addr_snap <= '0;
            src_addr  <= 1'b1;
            oe        <= 1'b0;
        end else begin
            addr      <= addr_nxt;
            addr_snap <= addr_snap_nxt;
            src_addr  <= src_addr_nxt;
            oe        <= oe_nxt;
        end
    end

    mem_mod_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr),
        .wdata (data),
        .rdata (ram_rdata)
    );

    // Read byte is the registered RAM output or the registered address snapshot.
    assign rd_byte = src_addr ? DATA_W'(addr_snap) : ram_rdata;

    assign data = oe ? rd_byte : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_mod.sv
// tb_mem_mod: directed bench for mem_mod with a reference model and an expected-data queue.
// The bus carries weak pull-ups, so a released bus reads 8'hFF.
module tb_mem_mod;
    import mem_mod_pkg::*;

`ifdef AUTO_INC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [4:0] cmd;
    logic       drv_en;
    logic [7:0] drv_val;
    wire  [7:0] data;

    logic [7:0] m_mem [256];
    logic [7:0] m_addr;
    logic [7:0] exp_q [$];
    int         checks;
    int         errors;

    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup pu (data[i]);
    end

    assign data = drv_en ? drv_val : 8'bzzzz_zzzz;

    mem_mod dut (
        .clk  (clk),
        .rst  (rst),
        .cmd  (cmd),
        .data (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One command cycle, entered and left on a falling edge.
    task automatic step(input logic sel, input logic [3:0] op, input logic [7:0] val,
                        input string tag);
        logic       rd;
        logic [7:0] e;
        rd      = 1'b0;
        cmd     = {sel, op};
        drv_val = val;
        drv_en  = (op == OP_SETADDR) || (op == OP_WRITE);
        if (sel) begin
            case (op)
                OP_SETADDR: m_addr = val;
                OP_WRITE: begin
                    m_mem[m_addr] = val;
                    if (AUTO) m_addr = m_addr + 8'd1;
                end
                OP_READ: begin
                    exp_q.push_back(m_mem[m_addr]);
                    rd = 1'b1;
                    if (AUTO) m_addr = m_addr + 8'd1;
                end
                OP_GETADDR: begin
                    exp_q.push_back(m_addr);
                    rd = 1'b1;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        cmd    = '0;
        drv_en = 1'b0;
        @(negedge clk);
        if (rd) begin
            e = exp_q.pop_front();
            check(tag, data, e);
        end else begin
            check({tag, "_released"}, data, 8'hFF);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        cmd    = '0;
        drv_en = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_bus", data, 8'hFF);
        end
        rst    = 1'b0;
        m_addr = 8'h00;
        exp_q.delete();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        cmd     = '0;
        drv_en  = 1'b0;
        drv_val = 8'h00;
        m_addr  = 8'h00;
        @(negedge clk);

        // Reset, then address readback.
        do_reset();
        step(1'b1, OP_GETADDR, 8'h00, "getaddr_after_reset");
        step(1'b1, OP_NOP,     8'h00, "nop1");

        // Write then read back.
        step(1'b1, OP_SETADDR, 8'h10, "setaddr10");
        step(1'b1, OP_WRITE,   8'hA5, "write_a5");
        step(1'b1, OP_SETADDR, 8'h10, "setaddr10b");
        step(1'b1, OP_READ,    8'h00, "read_a5");
        step(1'b1, OP_NOP,     8'h00, "after_read");

        // Deselected write has no effect.
        step(1'b1, OP_SETADDR, 8'h10, "setaddr10c");
        step(1'b0, OP_WRITE,   8'hFF, "nosel_write");
        step(1'b1, OP_READ,    8'h00, "read_still_a5");
        step(1'b1, OP_NOP,     8'h00, "nop2");

        // Address wrap with auto-increment, or plain overwrite without it.
        step(1'b1, OP_SETADDR, 8'h00, "setaddr00");
        step(1'b1, OP_WRITE,   8'h5A, "write_5a");
        step(1'b1, OP_SETADDR, 8'hFF, "setaddrff");
        step(1'b1, OP_WRITE,   8'h11, "write_11");
        step(1'b1, OP_WRITE,   8'h22, "write_22");
        step(1'b1, OP_GETADDR, 8'h00, "getaddr_wrap");
        step(1'b1, OP_NOP,     8'h00, "nop3");
        step(1'b1, OP_SETADDR, 8'hFF, "setaddrff_b");
        step(1'b1, OP_READ,    8'h00, "read_mem_ff");
        step(1'b1, OP_NOP,     8'h00, "nop4");
        step(1'b1, OP_SETADDR, 8'h00, "setaddr00_b");
        step(1'b1, OP_READ,    8'h00, "read_mem_00");
        step(1'b1, OP_NOP,     8'h00, "nop5");

        // Back-to-back reads hold the bus with no release gap.
        step(1'b1, OP_SETADDR, 8'h30, "setaddr30");
        step(1'b1, OP_WRITE,   8'h31, "write_31");
        step(1'b1, OP_SETADDR, 8'h31, "setaddr31");
        step(1'b1, OP_WRITE,   8'h32, "write_32");
        step(1'b1, OP_SETADDR, 8'h32, "setaddr32");
        step(1'b1, OP_WRITE,   8'h33, "write_33");
        step(1'b1, OP_SETADDR, 8'h30, "setaddr30_b");
        step(1'b1, OP_READ,    8'h00, "burst_read0");
        step(1'b1, OP_READ,    8'h00, "burst_read1");
        step(1'b1, OP_READ,    8'h00, "burst_read2");
        step(1'b1, OP_GETADDR, 8'h00, "burst_getaddr");
        step(1'b1, OP_NOP,     8'h00, "after_burst");

        // Reset right after a read drops the bus and clears the address.
        step(1'b1, OP_SETADDR, 8'h10, "setaddr10d");
        step(1'b1, OP_READ,    8'h00, "read_before_rst");
        do_reset();
        step(1'b1, OP_GETADDR, 8'h00, "getaddr_after_midrst");
        step(1'b1, OP_NOP,     8'h00, "nop6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
